elastic_pipe_stage: RTL and testbench
=====================================

# elastic_pipe_stage

Parametrised elastic pipeline stage with valid/ready handshake, a configurable-depth skid buffer, and a synchronous flush. It replaces the single-entry hand-coded inter-stage registers (IF/ID, ID/EX, EX/MEM, MEM/WB) with one generic block. Each stage's fields are packed into a `DataWidth` payload. With `Depth >= 2`, `ready_o` is fully registered, which breaks the backward ready path between stages.

## Interface
- `DataWidth`, 32: payload width in bits, >= 1.
- `Depth`, 2: number of storage entries, 1..8. Non-power-of-two values are legal.
- `ClearDataOnReset`, 0: 1 = storage is cleared to 0 on reset; 0 = storage is not reset.
- `clk_i` in 1: clock. All logic is on `posedge`.
- `reset_ni` in 1: reset, asynchronous and active-low.
- `flush_i` in 1: synchronous kill of all held entries. Drives branch-mispredict flushes.
- `data_i` in `DataWidth`: upstream payload.
- `valid_i` in 1: upstream has a valid payload.
- `ready_o` out 1: stage accepts a payload this cycle.
- `data_o` out `DataWidth`: oldest held payload.
- `valid_o` out 1: `data_o` is valid.
- `ready_i` in 1: downstream accepts this cycle.
- `count_o` out `$clog2(Depth+1)`: number of entries held.

## Operation
- **Storage:** circular buffer `mem[Depth]` with `wr_ptr`, `rd_ptr` and `count`.
  - Pointer width is `max(1, $clog2(Depth))`.
  - Pointers wrap from `Depth-1` to 0 by explicit compare, not by natural overflow.
- **Transfers:**
  - push = `valid_i & ready_o & ~flush_i`
  - pop = `valid_o & ready_i & ~flush_i`
- **Count update:**
  - push only: +1
  - pop only: -1
  - push and pop together: unchanged; both pointers advance.
- **Outputs:**
  - `valid_o = (count != 0)`
  - `data_o = mem[rd_ptr]`
  - `data_o` holds its last value while `valid_o` = 0.
- **`ready_o`:**
  - `Depth >= 2`: `ready_o = (count < Depth)`, a function of registered state only.
  - `Depth == 1`: `ready_o = (count == 0) | ready_i`. This gives full throughput with a single entry: the combinational ready path remains, as in the prior stages.
- **Flush:**
  - When `flush_i` = 1, the next state is `count` = 0 and `wr_ptr` = `rd_ptr` = 0.
  - A payload offered in the flush cycle is discarded.
  - A pop in the flush cycle does not count; downstream must also qualify with flush.
  - Storage contents are untouched by flush.
- **Reset (`reset_ni` = 0, asynchronous):**
  - `count`, `wr_ptr`, `rd_ptr` go to 0, so `valid_o` = 0 and `count_o` = 0.
  - `ready_o` = 1.
  - `data_o` = 0 if `ClearDataOnReset` = 1, otherwise undefined.
  - Reset mid-transfer drops all entries. No partial state survives.
- **Boundary conditions:**
  - Full (`Depth >= 2`): push is blocked even if a pop occurs that cycle.
  - Empty: there is no bypass. A payload pushed at cycle N is visible at `data_o` at cycle N+1.
  - Writes with `valid_i` = 0 never modify storage.

## Timing
- Latency: 1 cycle from push to `valid_o`.
- Throughput: 1 transfer per cycle in steady state for every `Depth`.
- `valid_o` and `data_o` come from registers only, with no combinational path from inputs.
- `ready_o` has a combinational path from `ready_i` only when `Depth == 1`.
- Flush takes effect at the next clock edge: `valid_o` = 0 one cycle after `flush_i` is sampled high.
- Once `valid_o` is asserted, it stays high with `data_o` stable until a pop or flush.

## Structure
- Shared package `pipe_pkg` holds the per-stage payload structs used with `DataWidth = $bits(...)`:
  - `if_id_t`, `id_ex_t`, `ex_mem_t`
  - `mem_wb_t`: `mem_data` 32, `mem_address` 32, `rd` 4, `RegWrite` 1, `MemToReg` 1 (70 bits).
- No sub-module. Storage, pointers and count are inline in this block.
- Generate branch on `Depth == 1` for the `ready_o` equation only.

## Test plan
- Reset, then `Depth=2`: push 0xA1, 0xA2 with `ready_i` = 0 -> `count_o` = 2, `ready_o` = 0, `data_o` = 0xA1. Raise `ready_i` -> 0xA1 then 0xA2 pop on consecutive cycles.
- `Depth=1`, `valid_i` and `ready_i` both held 1 for 16 cycles with incrementing data 0..15 -> one pop per cycle, outputs 0..15 in order, `valid_o` never drops after the first cycle.
- `Depth=3`: push 7 items with `ready_i` toggling 1/0 -> FIFO order preserved across pointer wrap, `count_o` never exceeds 3.
- Full `Depth=2` buffer, `flush_i` = 1 with `valid_i` = 1 (0xFF) -> next cycle `valid_o` = 0, `count_o` = 0, `ready_o` = 1. 0xFF never appears at the output.
- Assert `reset_ni` = 0 asynchronously mid-cycle with 1 entry held -> `valid_o` = 0 immediately, without waiting for a clock edge. With `ClearDataOnReset` = 1, `data_o` = 0.
- `Depth=2`, `count` = 1, simultaneous push 0x33 and pop -> `count_o` stays 1, `data_o` = 0x33 next cycle.

Source files
------------

// File: rtl/pipe_pkg.sv
// Per-stage payload structs carried through elastic_pipe_stage instances.
package pipe_pkg;

    localparam int unsigned XLEN     = 32;
    localparam int unsigned RegIdxW  = 4;

    // Fetch -> decode payload.
    typedef struct packed {
        logic [XLEN-1:0] instr;
        logic [XLEN-1:0] pc;
    } if_id_t;

    // Decode -> execute payload.
    typedef struct packed {
        logic [XLEN-1:0]    rs1_data;
        logic [XLEN-1:0]    rs2_data;
        logic [XLEN-1:0]    imm;
        logic [RegIdxW-1:0] rd;
        logic [3:0]         alu_op;
        logic               alu_src;
        logic               MemRead;
        logic               MemWrite;
        logic               RegWrite;
        logic               MemToReg;
    } id_ex_t;

    // Execute -> memory payload.
    typedef struct packed {
        logic [XLEN-1:0]    alu_result;
        logic [XLEN-1:0]    store_data;
        logic [RegIdxW-1:0] rd;
        logic               MemRead;
        logic               MemWrite;
        logic               RegWrite;
        logic               MemToReg;
    } ex_mem_t;

    // Memory -> writeback payload (70 bits).
    typedef struct packed {
        logic [XLEN-1:0]    mem_data;
        logic [XLEN-1:0]    mem_address;
        logic [RegIdxW-1:0] rd;
        logic               RegWrite;
        logic               MemToReg;
    } mem_wb_t;

endpackage

// File: rtl/elastic_pipe_stage.sv
// Generic valid/ready pipeline register with a Depth-entry skid buffer and flush.
module elastic_pipe_stage #(
    parameter int unsigned DataWidth        = 32,
    parameter int unsigned Depth            = 2,
    parameter int unsigned ClearDataOnReset = 0
) (
    input  logic                         clk_i,
    input  logic                         reset_ni,
    input  logic                         flush_i,
    input  logic [DataWidth-1:0]         data_i,
    input  logic                         valid_i,
    output logic                         ready_o,
    output logic [DataWidth-1:0]         data_o,
    output logic                         valid_o,
    input  logic                         ready_i,
    output logic [$clog2(Depth+1)-1:0]   count_o
);

    localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
    localparam int unsigned CntW = $clog2(Depth + 1);
    localparam logic [PtrW-1:0] LastPtr  = PtrW'(Depth - 1);
    localparam logic [CntW-1:0] DepthCnt = CntW'(Depth);

    logic [DataWidth-1:0] mem [Depth];
    logic [PtrW-1:0]      wr_ptr;
    logic [PtrW-1:0]      rd_ptr;
    logic [PtrW-1:0]      wr_ptr_nxt;
    logic [PtrW-1:0]      rd_ptr_nxt;
    logic [CntW-1:0]      count;
    logic                 push;
    logic                 pop;

    // Handshake qualification; a flush cycle never transfers in either direction.
    always_comb begin
        push       = valid_i & ready_o & ~flush_i;
        pop        = valid_o & ready_i & ~flush_i;
        wr_ptr_nxt = (wr_ptr == LastPtr) ? '0 : wr_ptr + PtrW'(1);
        rd_ptr_nxt = (rd_ptr == LastPtr) ? '0 : rd_ptr + PtrW'(1);
    end

    // Pointer and occupancy state; flush and reset both return to empty.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr_nxt;
            end
            if (pop) begin
                rd_ptr <= rd_ptr_nxt;
            end
            if (push && !pop) begin
                count <= count + CntW'(1);
            end else if (pop && !push) begin
                count <= count - CntW'(1);
            end
        end
    end

    // Payload storage; written only on an accepted push, never touched by flush.
    generate
        if (ClearDataOnReset != 0) begin : g_mem_clr
            always_ff @(posedge clk_i or negedge reset_ni) begin
                if (!reset_ni) begin
                    mem <= '{default: '0};
                end else if (push) begin
                    mem[wr_ptr] <= data_i;
                end
            end
        end else begin : g_mem_noclr
            always_ff @(posedge clk_i) begin
                if (push) begin
                    mem[wr_ptr] <= data_i;
                end
            end
        end
    endgenerate

    // Downstream view comes straight from registered state.
    always_comb begin
        valid_o = (count != '0);
        data_o  = mem[rd_ptr];
        count_o = count;
    end

    // Single entry keeps the ready_i pass-through for full rate; deeper buffers register it.
    generate
        if (Depth == 1) begin : g_ready_pass
            assign ready_o = (count == '0) | ready_i;
        end else begin : g_ready_reg
            assign ready_o = (count < DepthCnt);
        end
    endgenerate

endmodule

// File: tb/tb_elastic_pipe_stage.sv
// Directed bench for elastic_pipe_stage at Depth 1, 2 and 3.
module tb_elastic_pipe_stage;

    logic clk;
    logic reset_n;

    // Depth=2, cleared storage
    logic       f2, v2, r2, ro2, vo2;
    logic [7:0] d2, q2;
    logic [1:0] c2;
    // Depth=1
    logic       f1, v1, r1, ro1, vo1;
    logic [7:0] d1, q1;
    logic [0:0] c1;
    // Depth=3
    logic       f3, v3, r3, ro3, vo3;
    logic [7:0] d3, q3;
    logic [1:0] c3;

    int checks   = 0;
    int failures = 0;

    elastic_pipe_stage #(.DataWidth(8), .Depth(2), .ClearDataOnReset(1)) u_d2 (
        .clk_i(clk), .reset_ni(reset_n), .flush_i(f2), .data_i(d2), .valid_i(v2),
        .ready_o(ro2), .data_o(q2), .valid_o(vo2), .ready_i(r2), .count_o(c2));

    elastic_pipe_stage #(.DataWidth(8), .Depth(1), .ClearDataOnReset(0)) u_d1 (
        .clk_i(clk), .reset_ni(reset_n), .flush_i(f1), .data_i(d1), .valid_i(v1),
        .ready_o(ro1), .data_o(q1), .valid_o(vo1), .ready_i(r1), .count_o(c1));

    elastic_pipe_stage #(.DataWidth(8), .Depth(3), .ClearDataOnReset(0)) u_d3 (
        .clk_i(clk), .reset_ni(reset_n), .flush_i(f3), .data_i(d3), .valid_i(v3),
        .ready_o(ro3), .data_o(q3), .valid_o(vo3), .ready_i(r3), .count_o(c3));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    typedef struct {
        logic       v;
        logic [7:0] d;
        logic       r;
        logic       f;
        logic       ev;
        logic [7:0] ed;
        logic [1:0] ec;
        logic       er;
    } vec_t;

    vec_t tbl [17];

    initial begin
        logic [7:0] model [$];
        int         sent;
        int         got;
        int         cyc;
        logic       mpush;
        logic       mpop;

        // Expected state after the clock edge that samples each row.
        tbl[0]  = '{1'b1, 8'hA1, 1'b0, 1'b0, 1'b1, 8'hA1, 2'd1, 1'b1};
        tbl[1]  = '{1'b1, 8'hA2, 1'b0, 1'b0, 1'b1, 8'hA1, 2'd2, 1'b0};
        tbl[2]  = '{1'b1, 8'hA3, 1'b0, 1'b0, 1'b1, 8'hA1, 2'd2, 1'b0};
        tbl[3]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'hA2, 2'd1, 1'b1};
        tbl[4]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 2'd0, 1'b1};
        tbl[5]  = '{1'b1, 8'hB1, 1'b0, 1'b0, 1'b1, 8'hB1, 2'd1, 1'b1};
        tbl[6]  = '{1'b1, 8'hB2, 1'b0, 1'b0, 1'b1, 8'hB1, 2'd2, 1'b0};
        tbl[7]  = '{1'b1, 8'hB3, 1'b1, 1'b0, 1'b1, 8'hB2, 2'd1, 1'b1};
        tbl[8]  = '{1'b1, 8'h33, 1'b1, 1'b0, 1'b1, 8'h33, 2'd1, 1'b1};
        tbl[9]  = '{1'b1, 8'h44, 1'b0, 1'b0, 1'b1, 8'h33, 2'd2, 1'b0};
        tbl[10] = '{1'b1, 8'hFF, 1'b1, 1'b1, 1'b0, 8'h00, 2'd0, 1'b1};
        tbl[11] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 2'd0, 1'b1};
        tbl[12] = '{1'b1, 8'h55, 1'b0, 1'b0, 1'b1, 8'h55, 2'd1, 1'b1};
        tbl[13] = '{1'b1, 8'hFF, 1'b0, 1'b1, 1'b0, 8'h00, 2'd0, 1'b1};
        tbl[14] = '{1'b1, 8'h66, 1'b0, 1'b0, 1'b1, 8'h66, 2'd1, 1'b1};
        tbl[15] = '{1'b0, 8'hEE, 1'b0, 1'b0, 1'b1, 8'h66, 2'd1, 1'b1};
        tbl[16] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 2'd0, 1'b1};

        reset_n = 1'b0;
        {f1, v1, r1, d1} = '0;
        {f2, v2, r2, d2} = '0;
        {f3, v3, r3, d3} = '0;
        repeat (2) @(negedge clk);

        // Reset state
        chk("rst_valid_d2", 32'(vo2), 32'd0);
        chk("rst_count_d2", 32'(c2), 32'd0);
        chk("rst_ready_d2", 32'(ro2), 32'd1);
        chk("rst_data_d2", 32'(q2), 32'd0);
        chk("rst_valid_d1", 32'(vo1), 32'd0);
        chk("rst_ready_d1", 32'(ro1), 32'd1);
        chk("rst_valid_d3", 32'(vo3), 32'd0);
        chk("rst_count_d3", 32'(c3), 32'd0);
        reset_n = 1'b1;

        // Depth=2 vector table
        for (int i = 0; i < 17; i++) begin
            @(negedge clk);
            v2 = tbl[i].v;
            d2 = tbl[i].d;
            r2 = tbl[i].r;
            f2 = tbl[i].f;
            @(posedge clk);
            #1;
            chk($sformatf("d2_valid_%0d", i), 32'(vo2), 32'(tbl[i].ev));
            chk($sformatf("d2_count_%0d", i), 32'(c2), 32'(tbl[i].ec));
            chk($sformatf("d2_ready_%0d", i), 32'(ro2), 32'(tbl[i].er));
            if (tbl[i].ev) begin
                chk($sformatf("d2_data_%0d", i), 32'(q2), 32'(tbl[i].ed));
            end
        end
        @(negedge clk);
        {v2, r2, f2} = '0;

        // Depth=1 streaming at one transfer per cycle
        r1 = 1'b1;
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            v1 = 1'b1;
            d1 = 8'(k);
            @(posedge clk);
            #1;
            chk($sformatf("d1_valid_%0d", k), 32'(vo1), 32'd1);
            chk($sformatf("d1_data_%0d", k), 32'(q1), 32'(k));
            chk($sformatf("d1_ready_%0d", k), 32'(ro1), 32'd1);
        end
        @(negedge clk);
        v1 = 1'b0;
        @(posedge clk);
        #1;
        chk("d1_drain_valid", 32'(vo1), 32'd0);
        chk("d1_drain_count", 32'(c1), 32'd0);
        @(negedge clk);
        v1 = 1'b1;
        d1 = 8'hAA;
        r1 = 1'b0;
        @(posedge clk);
        #1;
        v1 = 1'b0;
        chk("d1_hold_count", 32'(c1), 32'd1);
        chk("d1_hold_data", 32'(q1), 32'hAA);
        chk("d1_full_ready", 32'(ro1), 32'd0);
        r1 = 1'b1;
        #1;
        chk("d1_ready_passthru", 32'(ro1), 32'd1);
        @(posedge clk);
        #1;
        chk("d1_final_valid", 32'(vo1), 32'd0);

        // Depth=3 FIFO order across wrap with toggling ready
        sent = 0;
        got  = 0;
        cyc  = 0;
        while ((sent < 7 || model.size() != 0) && cyc < 60) begin
            @(negedge clk);
            v3 = (sent < 7);
            d3 = 8'h10 + 8'(sent);
            r3 = (cyc % 2) == 1;
            chk($sformatf("d3_ready_%0d", cyc), 32'(ro3), 32'(model.size() < 3));
            mpush = v3 && (model.size() < 3);
            mpop  = (model.size() != 0) && r3;
            @(posedge clk);
            #1;
            if (mpop) begin
                void'(model.pop_front());
                got++;
            end
            if (mpush) begin
                model.push_back(d3);
                sent++;
            end
            chk($sformatf("d3_count_%0d", cyc), 32'(c3), 32'(model.size()));
            chk($sformatf("d3_valid_%0d", cyc), 32'(vo3), 32'(model.size() != 0));
            if (c3 > 2'd3) begin
                chk("d3_count_bound", 32'(c3), 32'd3);
            end
            if (model.size() != 0) begin
                chk($sformatf("d3_data_%0d", cyc), 32'(q3), 32'(model[0]));
            end
            cyc++;
        end
        chk("d3_popped_total", 32'(got), 32'd7);
        @(negedge clk);
        {v3, r3} = '0;

        // Asynchronous reset mid-cycle with one entry held
        @(negedge clk);
        v2 = 1'b1;
        d2 = 8'h77;
        r2 = 1'b0;
        @(posedge clk);
        #1;
        v2 = 1'b0;
        chk("ar_pre_valid", 32'(vo2), 32'd1);
        chk("ar_pre_data", 32'(q2), 32'h77);
        #2;
        reset_n = 1'b0;
        #1;
        chk("ar_valid", 32'(vo2), 32'd0);
        chk("ar_count", 32'(c2), 32'd0);
        chk("ar_ready", 32'(ro2), 32'd1);
        chk("ar_data", 32'(q2), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        chk("ar_after_valid", 32'(vo2), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
